// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: funct3 branch conditions, next-PC selects, BHT counter states.
// Pure definitions; no latency or backpressure of their own.
package branch_predict_unit_pkg;

  localparam logic [2:0] FUNCT3_BRANCH_EQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_NE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_LT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_GE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_LTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_GEU = 3'b111;

  typedef enum logic [1:0] {
    PC_NEXT_INST        = 2'b00,
    PC_BRANCH_OFFSET    = 2'b01,
    PC_ALU_RESULT       = 2'b10,
    PC_RECOVER_FALLTHRU = 2'b11
  } pc_src_e;

  localparam logic [1:0] BHT_STRONG_NT = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] BHT_WEAK_T    = 2'b10;
  localparam logic [1:0] BHT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-predict and execute-resolve signal bundle between the core pipeline and the branch predict unit.
// Wires only; latency and backpressure are defined by the modules on either side (none here).
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [XLEN-1:0]  res_pc;
  logic             branch;
  logic             jump;
  logic [2:0]       funct3;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_ltu;
  logic             res_pred_taken;
  logic [1:0]       pc_source;
  logic             flush;
  logic             illegal_branch;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output pred_pc, res_valid, res_pc, branch, jump, funct3,
           cmp_eq, cmp_lt, cmp_ltu, res_pred_taken,
    input  pred_taken, pc_source, flush, illegal_branch, br_count, mis_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, branch, jump, funct3,
           cmp_eq, cmp_lt, cmp_ltu, res_pred_taken,
    output pred_taken, pc_source, flush, illegal_branch, br_count, mis_count
  );
endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state logic for one 2-bit saturating BHT counter: step toward taken or not-taken, clamp at the ends.
// Combinational, zero latency; no backpressure.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] state,
  input  logic       inc,
  output logic [1:0] next
);
  always_comb begin
    next = state;
    if (inc) begin
      if (state != BHT_STRONG_T) next = state + 2'd1;
    end else begin
      if (state != BHT_STRONG_NT) next = state - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT predictor with execute-stage branch/jump resolution, next-PC select, flush and perf counters.
// Prediction and resolve outputs combinational; table/counters update on the resolve-cycle edge; no backpressure.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bus
);
  localparam int               ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          bht [ENTRIES];
  logic                cond_taken;
  logic                rsvd_f3;
  logic                upd;
  pc_src_e             pc_src;
  logic                flush_c;
  logic [CNT_W-1:0]    br_q;
  logic [CNT_W-1:0]    mis_q;

  assign pred_idx = bus.pred_pc[IDX_BITS+1:2];
  assign res_idx  = bus.res_pc[IDX_BITS+1:2];

  always_comb begin
    cond_taken = 1'b0;
    rsvd_f3    = 1'b0;
    case (bus.funct3)
      FUNCT3_BRANCH_EQ:  cond_taken = bus.cmp_eq;
      FUNCT3_BRANCH_NE:  cond_taken = ~bus.cmp_eq;
      FUNCT3_BRANCH_LT:  cond_taken = bus.cmp_lt;
      FUNCT3_BRANCH_GE:  cond_taken = ~bus.cmp_lt;
      FUNCT3_BRANCH_LTU: cond_taken = bus.cmp_ltu;
      FUNCT3_BRANCH_GEU: cond_taken = ~bus.cmp_ltu;
      default:           rsvd_f3    = 1'b1;
    endcase
  end

  // Jumps share the resolve slot but must never train the table or the counters.
  assign upd = bus.res_valid & bus.branch & ~bus.jump & ~rsvd_f3;

  always_comb begin
    pc_src  = PC_NEXT_INST;
    flush_c = 1'b0;
    if (!bus.res_valid) begin
      pc_src  = PC_NEXT_INST;
      flush_c = 1'b0;
    end else if (bus.jump) begin
      pc_src  = PC_ALU_RESULT;
      flush_c = 1'b1;
    end else if (bus.branch && cond_taken && !bus.res_pred_taken) begin
      pc_src  = PC_BRANCH_OFFSET;
      flush_c = 1'b1;
    end else if (bus.branch && !cond_taken && bus.res_pred_taken) begin
      pc_src  = PC_RECOVER_FALLTHRU;
      flush_c = 1'b1;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
    logic [1:0] entry_q;
    logic [1:0] entry_d;

    sat_counter2 u_sat (
      .state (entry_q),
      .inc   (cond_taken),
      .next  (entry_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) entry_q <= BHT_WEAK_NT;
      else if (upd && (res_idx == IDX_BITS'(i))) entry_q <= entry_d;
    end

    assign bht[i] = entry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (upd) begin
      if (br_q != CNT_MAX) br_q <= br_q + CNT_ONE;
      if ((cond_taken != bus.res_pred_taken) && (mis_q != CNT_MAX)) mis_q <= mis_q + CNT_ONE;
    end
  end

  // Table read is not bypassed: a same-index update shows up one cycle later.
  assign bus.pred_taken     = bht[pred_idx][1];
  assign bus.pc_source      = pc_src;
  assign bus.flush          = flush_c;
  assign bus.illegal_branch = bus.res_valid & bus.branch & rsvd_f3;
  assign bus.br_count       = br_q;
  assign bus.mis_count      = mis_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized checks of branch_predict_unit against a table-of-ints reference model.
module tb_branch_predict_unit;
  logic clk;
  logic rst_n;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) bus   ();
  branch_predict_unit_if #(.XLEN(32), .CNT_W(4))  bus_s ();

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .CNT_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one int per table entry holding 0..3, plain integer counters.
  int bht_m [64];
  int br_m;
  int mis_m;

  task automatic model_reset();
    for (int k = 0; k < 64; k++) bht_m[k] = 1;
    br_m  = 0;
    mis_m = 0;
  endtask

  function automatic bit cond_of(input logic [2:0] f3, input bit eq, input bit lt, input bit ltu);
    case (f3)
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit br, input bit j,
                       input logic [2:0] f3, input bit eq, input bit lt, input bit ltu,
                       input bit rpt, input logic [31:0] ppc);
    bus.res_valid = v;     bus_s.res_valid = v;
    bus.res_pc = pc;       bus_s.res_pc = pc;
    bus.branch = br;       bus_s.branch = br;
    bus.jump = j;          bus_s.jump = j;
    bus.funct3 = f3;       bus_s.funct3 = f3;
    bus.cmp_eq = eq;       bus_s.cmp_eq = eq;
    bus.cmp_lt = lt;       bus_s.cmp_lt = lt;
    bus.cmp_ltu = ltu;     bus_s.cmp_ltu = ltu;
    bus.res_pred_taken = rpt; bus_s.res_pred_taken = rpt;
    bus.pred_pc = ppc;     bus_s.pred_pc = ppc;
  endtask

  task automatic check_counts(input string tag);
    check(tag, "br_count",    64'(bus.br_count),    64'(br_m));
    check(tag, "mis_count",   64'(bus.mis_count),   64'(mis_m));
    check(tag, "br_count4",   64'(bus_s.br_count),  64'((br_m  > 15) ? 15 : br_m));
    check(tag, "mis_count4",  64'(bus_s.mis_count), 64'((mis_m > 15) ? 15 : mis_m));
  endtask

  // One resolve cycle: drive after the edge, check mid-cycle, then advance the model.
  task automatic step(input string tag, input bit v, input logic [31:0] pc, input bit br, input bit j,
                      input logic [2:0] f3, input bit eq, input bit lt, input bit ltu,
                      input bit rpt, input logic [31:0] ppc);
    bit       taken;
    bit       rsvd;
    bit       upd;
    bit       exp_pred;
    bit       exp_flush;
    logic [1:0] exp_src;
    int       ri;
    @(posedge clk);
    #1;
    drive(v, pc, br, j, f3, eq, lt, ltu, rpt, ppc);
    @(negedge clk);
    taken    = cond_of(f3, eq, lt, ltu);
    rsvd     = (f3 == 3'd2) || (f3 == 3'd3);
    exp_pred = bht_m[ppc[7:2]] >= 2;
    if (!v)                        begin exp_src = 2'd0; exp_flush = 1'b0; end
    else if (j)                    begin exp_src = 2'd2; exp_flush = 1'b1; end
    else if (br && taken && !rpt)  begin exp_src = 2'd1; exp_flush = 1'b1; end
    else if (br && !taken && rpt)  begin exp_src = 2'd3; exp_flush = 1'b1; end
    else                           begin exp_src = 2'd0; exp_flush = 1'b0; end
    check(tag, "pred_taken",     64'(bus.pred_taken),     64'(exp_pred));
    check(tag, "pc_source",      64'(bus.pc_source),      64'(exp_src));
    check(tag, "flush",          64'(bus.flush),          64'(exp_flush));
    check(tag, "illegal_branch", 64'(bus.illegal_branch), 64'(v && br && rsvd));
    check_counts(tag);
    upd = v && br && !j && !rsvd;
    if (upd) begin
      ri = int'(pc[7:2]);
      bht_m[ri] = taken ? ((bht_m[ri] == 3) ? 3 : bht_m[ri] + 1)
                        : ((bht_m[ri] == 0) ? 0 : bht_m[ri] - 1);
      br_m++;
      if (taken != rpt) mis_m++;
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rppc;

    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("in_reset", "pred_taken", 64'(bus.pred_taken), 64'(0));
    check_counts("in_reset");
    rst_n = 1'b1;

    step("reset_idle", 0, 32'h100, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    // Training: BEQ taken twice while predicted not-taken.
    step("train1", 1, 32'h100, 1, 0, 3'd0, 1, 0, 0, 0, 32'h100);
    step("train2", 1, 32'h100, 1, 0, 3'd0, 1, 0, 0, 0, 32'h100);
    step("train_done", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    // Recovery: BGE not taken while predicted taken.
    step("recover", 1, 32'h100, 1, 0, 3'd5, 0, 1, 0, 1, 32'h100);
    step("recover_done", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    // Jump overrides branch and leaves state untouched.
    step("jump", 1, 32'h100, 1, 1, 3'd0, 1, 0, 0, 0, 32'h100);
    step("jump_done", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    // Reserved funct3 values.
    step("rsvd010", 1, 32'h100, 1, 0, 3'd2, 1, 1, 1, 0, 32'h100);
    step("rsvd011", 1, 32'h100, 1, 0, 3'd3, 1, 1, 1, 0, 32'h100);
    step("rsvd_done", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    // Same-index read during update sees the old value, then the new one.
    step("collide", 1, 32'h40, 1, 0, 3'd1, 0, 0, 0, 0, 32'h40);
    step("collide_next", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h40);

    // Random traffic over a few aliased indices; pushes the 4-bit counters into saturation.
    for (int n = 0; n < 300; n++) begin
      rpc  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      rppc = ($urandom_range(0, 1) == 1) ? rpc
             : ((32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8));
      step("rand", $urandom_range(0, 3) != 0, rpc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rppc);
    end

    // Mid-sequence reset: state clears at assertion; a branch held during reset is ignored.
    step("pre_reset", 1, 32'h100, 1, 0, 3'd0, 1, 0, 0, 0, 32'h100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1, 32'h100, 1, 0, 3'd0, 1, 0, 0, 0, 32'h100);
    model_reset();
    #1;
    check("mid_reset", "pred_taken", 64'(bus.pred_taken), 64'(0));
    check_counts("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);
    step("post_reset", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100);

    for (int n = 0; n < 40; n++) begin
      rpc = (32'($urandom_range(0, 15)) << 2);
      step("rand2", 1, rpc, 1, 0, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rpc);
    end
    step("final", 0, 32'h0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
